// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one combinational multiplier through a
// two-stage registered pipeline. Define MULT_ARB_PERF_EN to add perf_grants.
module multiplier #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0]   x,
    input  logic [SIZE-1:0]   y,
    output logic [2*SIZE-1:0] p
);
    assign p = {{SIZE{1'b0}}, x} * {{SIZE{1'b0}}, y};
endmodule

module mult_arbiter #(
    parameter int SIZE = 4,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*SIZE-1:0] req_x,
    input  logic [NREQ*SIZE-1:0] req_y,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [2*SIZE-1:0]    resp_p
`ifdef MULT_ARB_PERF_EN
    ,
    output logic [15:0]          perf_grants
`endif
);
    localparam logic [IDW:0] NREQ_V = (IDW+1)'(NREQ);

    logic              a_vld, b_vld, a_adv, b_adv, any_valid, accept;
    logic [SIZE-1:0]   a_x, a_y, sel_x, sel_y;
    logic [IDW-1:0]    a_id, b_id, rr, rr_next, off, grant_idx;
    logic [IDW:0]      sum;
    logic [NREQ-1:0]   rot;
    logic [2*SIZE-1:0] prod, b_p;

    assign b_adv     = !b_vld || resp_ready;
    assign a_adv     = !a_vld || b_adv;
    assign any_valid = |req_valid;
    assign accept    = any_valid && a_adv && !flush;

    // Rotate so bit 0 is requester rr; the lowest set bit is the offset from rr.
    always_comb begin
        rot = NREQ'({req_valid, req_valid} >> rr);
        off = '0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (rot[i]) off = IDW'(i);
        end
        sum = {1'b0, rr} + {1'b0, off};
        if (sum >= NREQ_V) sum = sum - NREQ_V;
        grant_idx = sum[IDW-1:0];
    end

    // Gated by rst_n so nothing looks accepted while the block is held in reset.
    assign req_ready = (rst_n && accept) ? (NREQ'(1) << grant_idx) : '0;
    assign rr_next   = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_x = req_x[i*SIZE +: SIZE];
                sel_y = req_y[i*SIZE +: SIZE];
            end
        end
    end

    multiplier #(.SIZE(SIZE)) u_mult (
        .x(a_x),
        .y(a_y),
        .p(prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_vld <= 1'b0;
            a_x   <= '0;
            a_y   <= '0;
            a_id  <= '0;
            b_vld <= 1'b0;
            b_p   <= '0;
            b_id  <= '0;
            rr    <= '0;
        end else if (flush) begin
            a_vld <= 1'b0;
            b_vld <= 1'b0;
        end else begin
            if (b_adv) begin
                b_vld <= a_vld;
                if (a_vld) begin
                    b_p  <= prod;
                    b_id <= a_id;
                end
            end
            if (a_adv) begin
                a_vld <= accept;
                if (accept) begin
                    a_x  <= sel_x;
                    a_y  <= sel_y;
                    a_id <= grant_idx;
                    rr   <= rr_next;
                end
            end
        end
    end

    assign resp_valid = b_vld;
    assign resp_p     = b_p;
    assign resp_id    = b_id;

`ifdef MULT_ARB_PERF_EN
    // Saturating count of accepted requests; flush never touches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_grants <= '0;
        else if (accept && perf_grants != 16'hFFFF)
            perf_grants <= perf_grants + 16'd1;
    end
`endif
endmodule

// File: tb/tb_mult_arbiter.sv
// Testbench for mult_arbiter: vector table, hand-written corner sequences and a
// cycle-level reference model feeding a result scoreboard.
module tb_mult_arbiter;
    localparam int SIZE = 4;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk, rst_n, flush, resp_valid, resp_ready;
    logic [NREQ-1:0]      req_valid, req_ready;
    logic [NREQ*SIZE-1:0] req_x, req_y;
    logic [IDW-1:0]       resp_id;
    logic [2*SIZE-1:0]    resp_p;
`ifdef MULT_ARB_PERF_EN
    logic [15:0]          perf_grants;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int dut_delivered = 0;
    bit mon_en = 0;

    typedef struct {
        logic [IDW-1:0]    id;
        logic [2*SIZE-1:0] p;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [NREQ-1:0]   valid;
        logic              rresp;
        logic              fl;
        logic [NREQ-1:0]   exp_ready;
        logic              exp_rv;
        logic [IDW-1:0]    exp_id;
        logic [2*SIZE-1:0] exp_p;
    } vec_t;
    vec_t vecs[13];

    bit              m_a, m_b, m_acc, m_badv, m_aadv, m_take;
    int              m_rr, m_gnt, m_acc_id, m_perf;
    logic [NREQ-1:0] m_exp_ready;

    mult_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_p     (resp_p)
`ifdef MULT_ARB_PERF_EN
        ,
        .perf_grants(perf_grants)
`endif
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int model_grant(input logic [NREQ-1:0] v, input int start);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic exp_t make_exp(input int g);
        exp_t e;
        int xv, yv;
        xv = int'(req_x[g*SIZE +: SIZE]);
        yv = int'(req_y[g*SIZE +: SIZE]);
        e.id = IDW'(g);
        e.p  = (2*SIZE)'(xv * yv);
        return e;
    endfunction

    // Reference model of arbitration and stage occupancy.
    always_comb begin
        m_badv      = !m_b || resp_ready;
        m_aadv      = !m_a || m_badv;
        m_gnt       = model_grant(req_valid, m_rr);
        m_take      = m_aadv && !flush && (m_gnt >= 0);
        m_exp_ready = '0;
        if (m_take) m_exp_ready[m_gnt] = 1'b1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a    <= 0;
            m_b    <= 0;
            m_rr   <= 0;
            m_acc  <= 0;
            m_perf <= 0;
            exp_q.delete();
        end else if (flush) begin
            m_a   <= 0;
            m_b   <= 0;
            m_acc <= 0;
            exp_q.delete();
        end else begin
            if (m_b && resp_ready) void'(exp_q.pop_front());
            if (m_badv) m_b <= m_a;
            if (m_aadv) m_a <= m_take;
            m_acc    <= m_take;
            m_acc_id <= m_gnt;
            if (m_take) begin
                exp_q.push_back(make_exp(m_gnt));
                m_rr <= (m_gnt + 1) % NREQ;
                if (m_perf < 65535) m_perf <= m_perf + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ*SIZE-1:0] xs,
                                 input logic [NREQ*SIZE-1:0] ys, input logic rresp, input logic fl);
        req_valid  = v;
        req_x      = xs;
        req_y      = ys;
        resp_ready = rresp;
        flush      = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    // Every cycle: ready against the model, response against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            checkOutput("req_ready", 32'(req_ready), 32'(m_exp_ready));
            checkOutput("resp_valid", 32'(resp_valid), 32'(m_b));
            if (m_b && exp_q.size() > 0) begin
                checkOutput("sb_id", 32'(resp_id), 32'(exp_q[0].id));
                checkOutput("sb_p", 32'(resp_p), 32'(exp_q[0].p));
            end
            if (resp_valid && resp_ready) dut_delivered++;
`ifdef MULT_ARB_PERF_EN
            checkOutput("perf_grants", 32'(perf_grants), 32'(m_perf));
`endif
        end
    end

    initial begin
        logic [NREQ*SIZE-1:0] xs, ys, sx, sy;
        logic [NREQ-1:0]      sv;
        int                   nxt[NREQ];
        int                   k;
        bit                   finished;

        xs = {4'd4, 4'd13, 4'd2, 4'd1};
        ys = {4'd9, 4'd11, 4'd7, 4'd6};
        vecs[0]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, 2'd0, 8'd0};
        vecs[1]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 8'd0};
        vecs[2]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd2, 8'd143};
        vecs[3]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0, 8'd0};
        vecs[4]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3, 8'd36};
        vecs[5]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3, 8'd36};
        vecs[6]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd3, 8'd36};
        vecs[7]  = '{4'b1111, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd0, 8'd6};
        vecs[8]  = '{4'b0011, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0, 8'd0};
        vecs[9]  = '{4'b0011, 1'b1, 1'b0, 4'b0010, 1'b0, 2'd0, 8'd0};
        vecs[10] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0, 8'd6};
        vecs[11] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 8'd14};
        vecs[12] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 8'd0};

        // Reset values, including req_ready held low with requests present.
        rst_n = 0;
        applyStimulus(4'b1111, xs, ys, 1'b1, 1'b0);
        #12;
        checkOutput("rst_req_ready", 32'(req_ready), 0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 0);
        checkOutput("rst_resp_p", 32'(resp_p), 0);
        checkOutput("rst_resp_id", 32'(resp_id), 0);
`ifdef MULT_ARB_PERF_EN
        checkOutput("rst_perf", 32'(perf_grants), 0);
`endif
        step();
        rst_n  = 1;
        mon_en = 1;

        // Round-robin with all requesters valid: grants 0,1,2,3,0,1.
        for (int c = 0; c < 6; c++) begin
            applyStimulus(4'b1111, xs, ys, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput("rr_grant", 32'(req_ready), 32'(1) << (c % 4));
            if (c >= 2) begin
                checkOutput("rr_resp_valid", 32'(resp_valid), 1);
                checkOutput("rr_resp_id", 32'(resp_id), 32'((c - 2) % 4));
            end
            step();
        end
        applyStimulus('0, xs, ys, 1'b1, 1'b0);
        step();
        step();
        step();

        doReset();
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].valid, xs, ys, vecs[i].rresp, vecs[i].fl);
            @(negedge clk);
            checkOutput("vec_ready", 32'(req_ready), 32'(vecs[i].exp_ready));
            checkOutput("vec_resp_valid", 32'(resp_valid), 32'(vecs[i].exp_rv));
            if (vecs[i].exp_rv) begin
                checkOutput("vec_resp_id", 32'(resp_id), 32'(vecs[i].exp_id));
                checkOutput("vec_resp_p", 32'(resp_p), 32'(vecs[i].exp_p));
            end
            step();
        end

        // Backpressure: two results held for five cycles, then drained in order.
        sx = {4'd0, 4'd0, 4'd5, 4'd7};
        sy = {4'd0, 4'd0, 4'd6, 4'd9};
        applyStimulus(4'b0011, sx, sy, 1'b1, 1'b0);
        step();
        applyStimulus(4'b0010, sx, sy, 1'b1, 1'b0);
        step();
        for (int c = 0; c < 5; c++) begin
            applyStimulus(4'b1111, sx, sy, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("bp_ready", 32'(req_ready), 0);
            checkOutput("bp_hold_p", 32'(resp_p), 63);
            checkOutput("bp_hold_id", 32'(resp_id), 0);
            step();
        end
        applyStimulus('0, sx, sy, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("bp_drain0_p", 32'(resp_p), 63);
        step();
        @(negedge clk);
        checkOutput("bp_drain1_p", 32'(resp_p), 30);
        checkOutput("bp_drain1_id", 32'(resp_id), 1);
        step();
        @(negedge clk);
        checkOutput("bp_empty", 32'(resp_valid), 0);

        // Flush with both stages full, then a 15x15 request with latency 2.
        sx = {4'd15, 4'd0, 4'd2, 4'd3};
        sy = {4'd15, 4'd0, 4'd4, 4'd3};
        applyStimulus(4'b0011, sx, sy, 1'b0, 1'b0);
        step();
        step();
        applyStimulus('0, sx, sy, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("fl_full", 32'(resp_valid), 1);
        step();
        applyStimulus(4'b1000, sx, sy, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("fl_after_valid", 32'(resp_valid), 0);
        checkOutput("fl_new_ready", 32'(req_ready), 32'(4'b1000));
        step();
        applyStimulus('0, sx, sy, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("fl_lat1_valid", 32'(resp_valid), 0);
        step();
        @(negedge clk);
        checkOutput("fl_lat2_valid", 32'(resp_valid), 1);
        checkOutput("fl_lat2_p", 32'(resp_p), 225);
        checkOutput("fl_lat2_id", 32'(resp_id), 3);
        step();

        // Asynchronous reset mid-stream, then the first grant after release.
        applyStimulus(4'b1111, xs, ys, 1'b1, 1'b0);
        step();
        step();
        step();
        #1;
        rst_n = 0;
        #1;
        checkOutput("ar_resp_valid", 32'(resp_valid), 0);
        checkOutput("ar_req_ready", 32'(req_ready), 0);
        checkOutput("ar_resp_p", 32'(resp_p), 0);
        applyStimulus(4'b0110, xs, ys, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1;
        #1;
        checkOutput("ar_first_grant", 32'(req_ready), 32'(4'b0010));
        step();
        applyStimulus('0, xs, ys, 1'b1, 1'b0);
        step();
        step();
        step();

        // Sweep every operand pair, spread round-robin over requesters.
        doReset();
        dut_delivered = 0;
        finished = 0;
        for (int i = 0; i < NREQ; i++) nxt[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            finished = (exp_q.size() == 0);
            for (int i = 0; i < NREQ; i++) if (nxt[i] < 64) finished = 0;
            if (finished) break;
            sv = '0;
            sx = '0;
            sy = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (nxt[i] < 64) begin
                    k = nxt[i] * NREQ + i;
                    sv[i] = 1'b1;
                    sx[i*SIZE +: SIZE] = SIZE'(k >> 4);
                    sy[i*SIZE +: SIZE] = SIZE'(k & 15);
                end
            end
            applyStimulus(sv, sx, sy, $urandom_range(0, 3) != 0, 1'b0);
            step();
            if (m_acc) nxt[m_acc_id]++;
        end
        checkOutput("sweep_done", 32'(finished), 1);
        checkOutput("sweep_count", 32'(dut_delivered), 256);
`ifdef MULT_ARB_PERF_EN
        checkOutput("perf_final", 32'(perf_grants), 256);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
